// File: rtl/word_serializer.sv
// Parallel-in, serial-out unloader: captures D on LD and shifts it out one bit per SVALID/SREADY handshake.
// Optional trailing even-parity bit when WORD_SERIALIZER_PARITY_EN is defined.
module word_serializer #(
    parameter int width     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LD,
    input  logic [width-1:0] D,
    output logic             BUSY,
    output logic             SOUT,
    output logic             SVALID,
    input  logic             SREADY,
    output logic             DONE
);
    localparam int CW = $clog2(width + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [width-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             data_bit;
    logic             hs;

`ifdef WORD_SERIALIZER_PARITY_EN
    logic par_q, par_d;
`endif

    assign data_bit = MSB_FIRST ? sr_q[width-1] : sr_q[0];
    assign BUSY     = (state_q != S_IDLE);
    assign SVALID   = BUSY;
    assign hs       = SVALID & SREADY;
    assign DONE     = done_q;

    always_comb begin
        SOUT = 1'b0;
        if (state_q == S_SHIFT) SOUT = data_bit;
`ifdef WORD_SERIALIZER_PARITY_EN
        if (state_q == S_PARITY) SOUT = par_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (LD) begin
                    sr_d    = D;
                    cnt_d   = CW'(width);
                    state_d = S_SHIFT;
`ifdef WORD_SERIALIZER_PARITY_EN
                    par_d   = ^D;
`endif
                end
            end
            S_SHIFT: begin
                if (hs) begin
                    // Shift toward the output end, zero-filling behind.
                    sr_d  = MSB_FIRST ? {sr_q[width-2:0], 1'b0} : {1'b0, sr_q[width-1:1]};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            S_PARITY: begin
                if (hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench: a 32-bit MSB-first instance and an 8-bit LSB-first instance
// share clock and reset; expected words, parities and latencies are hand-computed constants.
module tb_word_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        ld32 = 1'b0, sready32 = 1'b0;
    logic [31:0] d32 = '0;
    logic        busy32, sout32, svalid32, done32;

    logic        ld8 = 1'b0, sready8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic        busy8, sout8, svalid8, done8;

    int checks = 0;
    int errors = 0;

    word_serializer #(.width(32), .MSB_FIRST(1'b1)) u32 (
        .CLK(clk), .RST_N(rst_n), .LD(ld32), .D(d32), .BUSY(busy32),
        .SOUT(sout32), .SVALID(svalid32), .SREADY(sready32), .DONE(done32)
    );

    word_serializer #(.width(8), .MSB_FIRST(1'b0)) u8 (
        .CLK(clk), .RST_N(rst_n), .LD(ld8), .D(d8), .BUSY(busy8),
        .SOUT(sout8), .SVALID(svalid8), .SREADY(sready8), .DONE(done8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; LD is seen at the next edge.
    task automatic load8(input logic [7:0] d);
        ld8 = 1'b1;
        d8  = d;
        @(posedge clk); #1;
        ld8 = 1'b0;
    endtask

    // Receives one LSB-first byte from u8 until DONE. Optional backpressure pattern,
    // a load attempt mid-word, and a chained load in the DONE cycle.
    task automatic rx8(input bit bp, input bit busy_ld, input bit chain, input logic [7:0] nxt,
                       output logic [7:0] got, output logic par, output int hs, output int lat);
        logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit   stalled = 1'b0;
        logic held = 1'b0;
        bit   seen = 1'b0;
        got = '0; par = 1'b0; hs = 0; lat = -1;
        for (int i = 0; i < 200; i++) begin
            sready8 = bp ? pat[i % 6] : 1'b1;
            ld8 = busy_ld && (i == 2);
            if (busy_ld && i == 2) d8 = 8'h00;
            @(negedge clk);
            if (i == 0) chk("first_valid", {svalid8, done8}, 2'b10);
            if (stalled) chk("stall_hold", sout8, held);
            if (done8) begin
                chk("done_idle", {busy8, svalid8, sout8}, 3'b000);
                lat  = i;
                seen = 1'b1;
                break;
            end
            stalled = svalid8 && !sready8;
            held    = sout8;
            if (svalid8 && sready8) begin
                if (hs < 8) got[hs[2:0]] = sout8;
                else par = sout8;
                hs++;
            end
            @(posedge clk); #1;
        end
        if (!seen) chk("done_timeout", 1'b0, 1'b1);
        ld8 = chain;
        d8  = nxt;
        @(posedge clk); #1;
        ld8 = 1'b0;
        if (!chain) begin
            @(negedge clk);
            chk("done_one_cycle", done8, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic word8(input string tag, input logic [7:0] d, input logic p, input bit bp);
        logic [7:0] got;
        logic par;
        int hs, lat;
        load8(d);
        rx8(bp, 1'b0, 1'b0, 8'h00, got, par, hs, lat);
        chk({tag, "_data"}, got, d);
        chk({tag, "_hs"}, hs, 8 + EXTRA);
        if (!bp) chk({tag, "_lat"}, lat, 8 + EXTRA);
`ifdef WORD_SERIALIZER_PARITY_EN
        chk({tag, "_par"}, par, p);
`else
        chk({tag, "_nopar"}, par, 1'b0);
        if (p) par = 1'b0;
`endif
    endtask

    initial begin
        logic [31:0] got32;
        logic [7:0]  got;
        logic        par32, par;
        int          n, lat, hs;

        repeat (2) @(posedge clk); #1;
        chk("rst_u8", {busy8, svalid8, sout8, done8}, 4'b0000);
        chk("rst_u32", {busy32, svalid32, sout32, done32}, 4'b0000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 32-bit MSB-first word, SREADY tied high.
        ld32 = 1'b1; d32 = 32'hA5A5_0F0F; sready32 = 1'b1;
        @(posedge clk); #1;
        ld32 = 1'b0;
        got32 = '0; par32 = 1'b0; n = 0; lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done32) begin lat = i; break; end
            if (svalid32 && sready32) begin
                if (n < 32) got32 = {got32[30:0], sout32};
                else par32 = sout32;
                n++;
            end
            @(posedge clk); #1;
        end
        chk("w32_data", got32, 32'hA5A5_0F0F);
        chk("w32_hs", n, 32 + EXTRA);
        chk("w32_lat", lat, 32 + EXTRA);
        chk("w32_par", par32, 1'b0);
        @(posedge clk); #1;

        word8("lsb_c1", 8'hC1, 1'b1, 1'b0);
        word8("bp_96", 8'h96, 1'b0, 1'b1);

        // Load while busy is ignored; load in the DONE cycle chains the next word.
        load8(8'hFF);
        rx8(1'b0, 1'b1, 1'b1, 8'h3C, got, par, hs, lat);
        chk("busy_ld_data", got, 8'hFF);
        chk("busy_ld_hs", hs, 8 + EXTRA);
        rx8(1'b0, 1'b0, 1'b0, 8'h00, got, par, hs, lat);
        chk("chain_data", got, 8'h3C);
        chk("chain_lat", lat, 8 + EXTRA);

        word8("p_07", 8'h07, 1'b1, 1'b0);
        word8("p_03", 8'h03, 1'b0, 1'b0);

        // Reset mid-word aborts immediately with no DONE.
        load8(8'h5A);
        sready8 = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_u8", {busy8, svalid8, sout8, done8}, 4'b0000);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_nodone", {done8, svalid8}, 2'b00);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {busy8, done8}, 2'b00);
        word8("post_rst_01", 8'h01, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-in, serial-out unloader that pairs with the team's parallel-load `LD`/`D` register. It captures a `width`-bit word on `LD` and shifts it out one bit per downstream valid/ready handshake. It sits between a datapath register and a bit-serial consumer such as a debug/UART-style link or an LED/scan chain. It pulses `DONE` once the word has been fully delivered.

## Interface
Parameters:
- `width`, 32: word size in bits; legal range 2..64.
- `MSB_FIRST`, 1: 1 = bit `width-1` is sent first; 0 = bit 0 is sent first.

Ports:
- `CLK`  in  1  rising-edge clock; the only clock.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `LD`  in  1  load request; sampled only while `BUSY`=0.
- `D`  in  `width`  parallel word, captured with `LD`.
- `BUSY`  out  1  high from the cycle after an accepted load until the final bit handshake completes.
- `SOUT`  out  1  current serial bit.
- `SVALID`  out  1  `SOUT` is valid.
- `SREADY`  in  1  consumer accepts `SOUT` this cycle.
- `DONE`  out  1  one-cycle pulse after the final handshake.

## Operation
- Internal state:
  - shift register `sr[width-1:0]`
  - down-counter `cnt` of width `$clog2(width+1)`
  - FSM with states IDLE, SHIFT and, under `PARITY_EN` only, PARITY.
- IDLE (`BUSY`=0, `SVALID`=0):
  - With `LD`=1 at the clock edge: `sr`<=`D`, `cnt`<=`width`, go to SHIFT.
  - With `LD`=0: stay in IDLE.
- SHIFT (`BUSY`=1, `SVALID`=1):
  - `SOUT` = `sr[width-1]` when `MSB_FIRST`=1, else `sr[0]`.
  - On an edge with `SVALID`&`SREADY`: shift `sr` toward the output end, filling with 0, and decrement `cnt`.
  - When `cnt`=1 at the handshake, that is the last data bit: go to PARITY if enabled, otherwise go to IDLE and set `DONE`.
- `LD` is ignored while `BUSY`=1. `D` is not sampled again and the word in flight is never corrupted.
- With `SVALID`=1 and `SREADY`=0: `SOUT`, `sr` and `cnt` hold. No bit is skipped or repeated.
- `SOUT` is 0 whenever `SVALID`=0.

## Timing
- Reset (`RST_N`=0, applied asynchronously): state=IDLE, `sr`=0, `cnt`=0, `BUSY`=0, `SVALID`=0, `SOUT`=0, `DONE`=0.
- Reset mid-word aborts the word immediately. No `DONE` is produced. The first edge after reset release is in IDLE.
- Load latency: `LD` sampled at edge k; `BUSY`/`SVALID` and the first bit are valid in the cycle after edge k.
- `DONE` is registered. It is high for exactly one cycle, the cycle following the final handshake edge. `BUSY` is 0 in that same cycle.
- Back-to-back: `LD`=1 during the `DONE` cycle is accepted. The next word's first bit appears in the following cycle.
- Throughput with `SREADY` tied 1: one word per `width`+1 cycles, or `width`+2 with `PARITY_EN`.
- `SREADY` may toggle arbitrarily. Only cycles with `SVALID`&`SREADY` advance the block.

## Configuration
- `WORD_SERIALIZER_PARITY_EN` defined:
  - On an accepted load, a parity bit P is stored as the XOR of all bits of `D` (even parity).
  - After the last data handshake the FSM enters PARITY. In PARITY: `SVALID`=1, `SOUT`=P, `BUSY`=1.
  - P is held until its handshake completes, then the FSM goes to IDLE and `DONE` pulses.
- `WORD_SERIALIZER_PARITY_EN` not defined:
  - The PARITY state and the P register do not exist.
  - A word is exactly `width` serial bits.

## Test plan
- Reset: assert `RST_N`=0 mid-word (`SVALID`=1) -> all outputs 0 immediately. No `DONE` pulse. After release, `LD` with `D`=0x0000_0001 restarts cleanly.
- MSB-first, `SREADY`=1, `width`=32: `LD` with `D`=0xA5A5_0F0F -> `SOUT` sequence 1,0,1,0,0,1,0,1,... ending 1,1,1,1. `DONE` pulses on cycle 33 after the `LD` edge.
- LSB-first (`MSB_FIRST`=0), `width`=8: `D`=0xC1 -> `SOUT` 1,0,0,0,0,0,1,1. One `DONE` pulse.
- Backpressure, `width`=8: `SREADY` pattern 1,0,0,1,0,1,... with `D`=0x96 -> the stalled bit stays stable, exactly 8 handshakes occur, and the received byte equals 0x96.
- Load while busy, `width`=8: `LD` with `D`=0xFF, then `LD` with `D`=0x00 during SHIFT -> output is 0xFF only. The second load is ignored. `LD`=1 during the `DONE` cycle with `D`=0x3C -> 0x3C starts the next cycle.
- With `WORD_SERIALIZER_PARITY_EN`, `width`=8: `D`=0x07 -> 8 data bits then P=1. `D`=0x03 -> P=0. `DONE` follows the parity handshake.
